// File: rtl/fifo_sched_pkg.sv
// Shared definitions for the FIFO burst scheduler: read-FSM state encoding
// and a small helper for the buffered-level test.
package fifo_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_FLUSH = 2'd2
   } rd_state_e;

   // Full FIFO reports usedw=0, so the full flag must be folded in separately.
   function automatic logic level_reached(input logic full, input logic [15:0] used,
                                          input logic [15:0] thresh);
      return full | (used >= thresh);
   endfunction

endpackage

// File: rtl/fifo_burst_sched_rr_arb2.sv
// Two-way round-robin grant for the FIFO write port; remembers the last
// winner so that two continuously valid producers alternate.
module rr_arb2 (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic block_i,
   input  logic req0_i,
   input  logic req1_i,
   output logic gnt0_o,
   output logic gnt1_o
);

   // 1 = producer 1 won last, so producer 0 is favoured next.
   logic last_q;
   logic last_d;

   always_comb begin
      gnt0_o = 1'b0;
      gnt1_o = 1'b0;
      if (sys_rst_n && !block_i) begin
         if (req0_i && (!req1_i || last_q)) begin
            gnt0_o = 1'b1;
         end else if (req1_i) begin
            gnt1_o = 1'b1;
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (gnt0_o) begin
         last_d = 1'b0;
      end else if (gnt1_o) begin
         last_d = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/fifo_burst_sched.sv
// FIFO controller: round-robin write arbitration of two producers and a
// burst/flush read scheduler feeding one downstream consumer.
module fifo_burst_sched
   import fifo_sched_pkg::*;
#(
   parameter int DW        = 8,
   parameter int AW        = 8,
   parameter int BURST_LEN = 16
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          src0_valid,
   input  logic [DW-1:0] src0_data,
   output logic          src0_ready,
   input  logic          src1_valid,
   input  logic [DW-1:0] src1_data,
   output logic          src1_ready,
   input  logic          flush,
   input  logic          dst_ready,
   output logic          dst_valid,
   output logic [DW-1:0] dst_data,
   output logic          burst_busy,
   output logic          fifo_wr_req,
   output logic [DW-1:0] fifo_wr_data,
   output logic          fifo_rd_req,
   input  logic [DW-1:0] fifo_q,
   input  logic          fifo_full,
   input  logic          fifo_empty,
   input  logic [AW-1:0] fifo_usedw
);

   // One extra bit so a burst of the full FIFO depth is representable.
   localparam logic [AW:0] BL = BURST_LEN[AW:0];

   logic gnt0;
   logic gnt1;
   logic avail;
   logic rd_req;

   rd_state_e   state_q;
   logic [AW:0] cnt_q;
   logic [AW:0] cnt_d;
   logic        pend_q;
   logic        busy_q;
   logic        dst_valid_q;

   // ---------------- write side ----------------
   rr_arb2 u_arb (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .block_i   (fifo_full),
      .req0_i    (src0_valid),
      .req1_i    (src1_valid),
      .gnt0_o    (gnt0),
      .gnt1_o    (gnt1)
   );

   assign src0_ready  = gnt0;
   assign src1_ready  = gnt1;
   assign fifo_wr_req = gnt0 | gnt1;

   always_comb begin
      fifo_wr_data = '0;
      if (gnt0) begin
         fifo_wr_data = src0_data;
      end else if (gnt1) begin
         fifo_wr_data = src1_data;
      end
   end

   // ---------------- read side ----------------
   assign avail = level_reached(fifo_full, 16'({1'b0, fifo_usedw}), 16'(BL));
   assign cnt_d = cnt_q + (AW+1)'(1);

   always_comb begin
      rd_req = 1'b0;
      if (sys_rst_n && (state_q == ST_BURST || state_q == ST_FLUSH)) begin
         rd_req = dst_ready & ~fifo_empty;
      end
   end

   assign fifo_rd_req = rd_req;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         busy_q      <= 1'b0;
         dst_valid_q <= 1'b0;
      end else begin
         dst_valid_q <= rd_req;

         // A new flush request beats the empty-FIFO clear in the same cycle.
         if (flush) begin
            pend_q <= 1'b1;
         end else if (fifo_empty && (state_q == ST_IDLE || state_q == ST_FLUSH)) begin
            pend_q <= 1'b0;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (pend_q && !fifo_empty) begin
                  state_q <= ST_FLUSH;
                  busy_q  <= 1'b1;
               end else if (avail) begin
                  state_q <= ST_BURST;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_BURST: begin
               // A flush arriving here is only latched; the burst always completes.
               if (rd_req) begin
                  cnt_q <= cnt_d;
                  if (cnt_d == BL) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end
            end
            ST_FLUSH: begin
               if (fifo_empty) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign burst_busy = busy_q;
   assign dst_valid  = dst_valid_q;
   assign dst_data   = sys_rst_n ? fifo_q : '0;

endmodule

// File: tb/tb_fifo_burst_sched.sv
// Bench for fifo_burst_sched: behavioural scfifo model, directed stimulus
// pushing expected read bytes into a queue, and a monitor that checks them.
module tb_fifo_burst_sched;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       src0_valid = 1'b0, src1_valid = 1'b0;
   logic [7:0] src0_data = 8'h00, src1_data = 8'h00;
   logic       src0_ready, src1_ready;
   logic       flush = 1'b0, dst_ready = 1'b0;
   logic       dst_valid, burst_busy;
   logic [7:0] dst_data;
   logic       fifo_wr_req, fifo_rd_req;
   logic [7:0] fifo_wr_data;
   logic [7:0] fifo_q;
   logic       fifo_full, fifo_empty;
   logic [7:0] fifo_usedw;

   always #5 sys_clk = ~sys_clk;

   fifo_burst_sched #(.DW(8), .AW(8), .BURST_LEN(16)) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .src0_valid   (src0_valid),
      .src0_data    (src0_data),
      .src0_ready   (src0_ready),
      .src1_valid   (src1_valid),
      .src1_data    (src1_data),
      .src1_ready   (src1_ready),
      .flush        (flush),
      .dst_ready    (dst_ready),
      .dst_valid    (dst_valid),
      .dst_data     (dst_data),
      .burst_busy   (burst_busy),
      .fifo_wr_req  (fifo_wr_req),
      .fifo_wr_data (fifo_wr_data),
      .fifo_rd_req  (fifo_rd_req),
      .fifo_q       (fifo_q),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .fifo_usedw   (fifo_usedw)
   );

   // ---------------- scfifo model (normal mode, 256 deep) ----------------
   logic [7:0] mem [0:255];
   logic [7:0] wp = 8'd0, rp = 8'd0, fq = 8'd0;
   logic [8:0] count = 9'd0;
   logic       fifo_clr = 1'b1;
   logic       wr_ok, rd_ok;

   assign wr_ok      = fifo_wr_req && (count != 9'd256);
   assign rd_ok      = fifo_rd_req && (count != 9'd0);
   assign fifo_full  = (count == 9'd256);
   assign fifo_empty = (count == 9'd0);
   assign fifo_usedw = count[7:0];
   assign fifo_q     = fq;

   always @(posedge sys_clk) begin
      if (fifo_clr) begin
         wp <= 8'd0; rp <= 8'd0; count <= 9'd0;
      end else begin
         if (wr_ok) begin
            mem[wp] <= fifo_wr_data;
            wp <= wp + 8'd1;
         end
         if (rd_ok) begin
            fq <= mem[rp];
            rp <= rp + 8'd1;
         end
         count <= count + {8'd0, wr_ok} - {8'd0, rd_ok};
      end
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q [$];
   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;

   initial begin : monitor
      logic prev_rd;
      logic [7:0] e;
      prev_rd = 1'b0;
      forever begin
         @(negedge sys_clk);
         if (!sys_rst_n) begin
            prev_rd = 1'b0;
         end else begin
            if (dst_valid || prev_rd) begin
               checks++;
               if (dst_valid !== prev_rd) begin
                  errors++;
                  $display("FAIL dvalid_lat: dst_valid=%0b, rd_req one cycle earlier=%0b", dst_valid, prev_rd);
               end
            end
            if (dst_valid) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL dst_unexpected: got %02h, expected no data", dst_data);
               end else begin
                  e = exp_q.pop_front();
                  if (dst_data !== e) begin
                     errors++;
                     $display("FAIL dst_data: got %02h expected %02h", dst_data, e);
                  end else begin
                     $display("read  %02h ok", dst_data);
                  end
               end
            end
            prev_rd = fifo_rd_req;
            if (fifo_rd_req) rd_cnt++;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send(input int src, input logic [7:0] d);
      int t;
      t = 0;
      if (src == 0) begin src0_valid = 1'b1; src0_data = d; end
      else begin src1_valid = 1'b1; src1_data = d; end
      @(negedge sys_clk);
      while (!((src == 0) ? src0_ready : src1_ready)) begin
         t++;
         if (t > 2000) begin
            checks++; errors++;
            $display("FAIL send_timeout: src%0d byte %02h never accepted", src, d);
            break;
         end
         @(negedge sys_clk);
      end
      @(posedge sys_clk);
      #1;
      if (src == 0) src0_valid = 1'b0; else src1_valid = 1'b0;
      $display("write src%0d %02h", src, d);
   endtask

   task automatic wait_busy(input logic val, input int bound, input string name);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < bound; k++) begin
         tick();
         if (burst_busy == val) begin ok = 1'b1; break; end
      end
      chk(name, int'(ok), 1);
   endtask

   task automatic do_reset(input logic clr);
      sys_rst_n = 1'b0; fifo_clr = clr;
      src0_valid = 1'b0; src1_valid = 1'b0; flush = 1'b0; dst_ready = 1'b0;
      repeat (2) tick();
      fifo_clr = 1'b0;
      sys_rst_n = 1'b1;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int base;
      int cyc;

      // Reset state: requests are blocked even with producers and consumer active.
      src0_valid = 1'b1; src1_valid = 1'b1; dst_ready = 1'b1;
      repeat (2) tick();
      @(negedge sys_clk);
      chk("rst_src0_ready", src0_ready, 0);
      chk("rst_src1_ready", src1_ready, 0);
      chk("rst_wr_req", fifo_wr_req, 0);
      chk("rst_rd_req", fifo_rd_req, 0);
      chk("rst_dst_valid", dst_valid, 0);
      chk("rst_busy", burst_busy, 0);
      do_reset(1'b1);

      // Single producer, 15 bytes: below threshold, no burst.
      dst_ready = 1'b1;
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
      for (int i = 0; i < 15; i++) send(0, 8'(i));
      repeat (4) tick();
      chk("t1_idle_at_15", burst_busy, 0);
      base = rd_cnt;
      send(0, 8'd15);
      wait_busy(1'b1, 4, "t1_burst_start");
      cyc = 1;
      for (int k = 0; k < 100 && burst_busy; k++) begin
         tick();
         if (burst_busy) cyc++;
      end
      chk("t1_busy_cycles", cyc, 16);
      chk("t1_reads", rd_cnt - base, 16);
      repeat (3) tick();
      chk("t1_queue_empty", exp_q.size(), 0);

      // Both producers, reads blocked: strict alternation then full.
      do_reset(1'b1);
      src0_data = 8'hA0; src1_data = 8'hB0;
      src0_valid = 1'b1; src1_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         @(negedge sys_clk);
         chk("t2_wr_req", fifo_wr_req, 1);
         chk("t2_wr_data", fifo_wr_data, (i % 2 == 0) ? 8'hA0 : 8'hB0);
      end
      $display("write 256 alternating A0/B0 bytes");
      repeat (2) begin
         @(negedge sys_clk);
         chk("t2_full_src0_ready", src0_ready, 0);
         chk("t2_full_src1_ready", src1_ready, 0);
         chk("t2_full_wr_req", fifo_wr_req, 0);
         chk("t2_full_rd_req", fifo_rd_req, 0);
      end
      do_reset(1'b1);

      // Flush of 5 words, then 9 words.
      dst_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin exp_q.push_back(8'h30 + 8'(i)); send(1, 8'h30 + 8'(i)); end
      repeat (3) tick();
      chk("t3_idle_5", burst_busy, 0);
      base = rd_cnt;
      pulse_flush();
      wait_busy(1'b1, 4, "t3_flush_enter");
      wait_busy(1'b0, 40, "t3_flush_exit");
      repeat (2) tick();
      chk("t3_reads_5", rd_cnt - base, 5);
      chk("t3_queue_empty", exp_q.size(), 0);
      for (int i = 0; i < 9; i++) begin exp_q.push_back(8'h40 + 8'(i)); send(1, 8'h40 + 8'(i)); end
      repeat (3) tick();
      chk("t3_idle_9", burst_busy, 0);
      chk("t3_no_reads_9", rd_cnt - base, 5);
      base = rd_cnt;
      pulse_flush();
      wait_busy(1'b1, 4, "t3_flush9_enter");
      wait_busy(1'b0, 40, "t3_flush9_exit");
      repeat (2) tick();
      chk("t3_reads_9", rd_cnt - base, 9);
      chk("t3_queue9_empty", exp_q.size(), 0);

      // Flush recorded at cnt=4 with 40 words: burst finishes, then flush drains.
      do_reset(1'b1);
      for (int i = 0; i < 40; i++) begin exp_q.push_back(8'(i)); send(0, 8'(i)); end
      chk("t4_in_burst", burst_busy, 1);
      base = rd_cnt;
      dst_ready = 1'b1;
      repeat (4) tick();
      dst_ready = 1'b0;
      chk("t4_cnt4", rd_cnt - base, 4);
      pulse_flush();
      dst_ready = 1'b1;
      wait_busy(1'b0, 100, "t4_burst_end");
      chk("t4_burst_reads", rd_cnt - base, 16);
      wait_busy(1'b1, 5, "t4_flush_enter");
      wait_busy(1'b0, 100, "t4_flush_end");
      repeat (2) tick();
      chk("t4_total_reads", rd_cnt - base, 40);
      chk("t4_queue_empty", exp_q.size(), 0);

      // dst_ready toggling during a burst.
      do_reset(1'b1);
      for (int i = 0; i < 16; i++) begin exp_q.push_back(8'h60 + 8'(i)); send(1, 8'h60 + 8'(i)); end
      wait_busy(1'b1, 4, "t5_burst_start");
      base = rd_cnt;
      for (int i = 0; i < 32; i++) begin
         dst_ready = (i % 2 == 0);
         @(negedge sys_clk);
         chk("t5_rd_follows_ready", fifo_rd_req, dst_ready);
         @(posedge sys_clk);
         #1;
      end
      dst_ready = 1'b0;
      chk("t5_reads", rd_cnt - base, 16);
      chk("t5_idle_after", burst_busy, 0);
      repeat (2) tick();
      chk("t5_queue_empty", exp_q.size(), 0);

      // Reset in the middle of a burst at cnt=7.
      do_reset(1'b1);
      for (int i = 0; i < 20; i++) send(0, 8'(i));
      for (int i = 0; i < 7; i++) exp_q.push_back(8'(i));
      base = rd_cnt;
      dst_ready = 1'b1;
      repeat (7) tick();
      dst_ready = 1'b0;
      chk("t6_cnt7", rd_cnt - base, 7);
      tick();
      dst_ready = 1'b1; src0_valid = 1'b1; src0_data = 8'h77;
      #1;
      chk("t6_pre_rd_req", fifo_rd_req, 1);
      chk("t6_pre_src0_ready", src0_ready, 1);
      #1;
      sys_rst_n = 1'b0;
      #1;
      chk("t6_rst_src0_ready", src0_ready, 0);
      chk("t6_rst_wr_req", fifo_wr_req, 0);
      chk("t6_rst_wr_data", fifo_wr_data, 0);
      chk("t6_rst_rd_req", fifo_rd_req, 0);
      chk("t6_rst_dst_valid", dst_valid, 0);
      chk("t6_rst_busy", burst_busy, 0);
      src0_valid = 1'b0;
      repeat (2) tick();
      sys_rst_n = 1'b1;
      base = rd_cnt;
      repeat (5) tick();
      chk("t6_idle_13", burst_busy, 0);
      chk("t6_no_reads_13", rd_cnt - base, 0);
      for (int i = 7; i < 20; i++) exp_q.push_back(8'(i));
      for (int i = 0; i < 3; i++) begin exp_q.push_back(8'h50 + 8'(i)); send(0, 8'h50 + 8'(i)); end
      wait_busy(1'b1, 4, "t6_burst_start");
      wait_busy(1'b0, 60, "t6_burst_end");
      repeat (2) tick();
      chk("t6_reads_16", rd_cnt - base, 16);
      chk("t6_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
